key_sideload_serializer: RTL



---
 rtl/key_sideload_serializer_pkg.sv | 30 +++
 rtl/key_slice_mux.sv | 37 +++
 rtl/key_sideload_serializer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/key_sideload_serializer_pkg.sv
// -----------------------------------------------------------------------------
// key_sideload_serializer_pkg
// Shared key definitions for the sideload key path: share count, key width,
// the sideload request type, the default output slice width and the state
// encoding of the key serializer.
// -----------------------------------------------------------------------------
package key_sideload_serializer_pkg;

    localparam int unsigned Shares    = 32'd2;
    localparam int unsigned KeyWidth  = 32'd64;
    localparam int unsigned WordWidth = 32'd32;
    localparam int unsigned NumWords  = KeyWidth / WordWidth;

    // Sideload request: all key shares, share 0 in the least significant bits.
    typedef struct packed {
        logic [Shares-1:0][KeyWidth-1:0] key;
    } hw_key_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WIPE = 2'd2
    } key_ser_state_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/key_slice_mux.sv
// -----------------------------------------------------------------------------
// key_slice_mux
// Pure combinational selection of one slice of a multi-share key:
//   word = key[share][idx*WordWidth +: WordWidth]
// Ports:
//   key   - flattened key, share s occupies bits [s*KeyWidth +: KeyWidth]
//   share - share index of the requested slice
//   idx   - slice index within the share
//   word  - selected slice (zero for an out-of-range index)
// -----------------------------------------------------------------------------
module key_slice_mux #(
    parameter int unsigned Shares    = 32'd2,
    parameter int unsigned KeyWidth  = 32'd64,
    parameter int unsigned WordWidth = 32'd32,
    parameter int unsigned ShareW    = 32'd1,
    parameter int unsigned IdxW      = 32'd1
) (
    input  logic [Shares*KeyWidth-1:0] key,
    input  logic [ShareW-1:0]          share,
    input  logic [IdxW-1:0]            idx,
    output logic [WordWidth-1:0]       word
);

    localparam int unsigned NumWords = KeyWidth / WordWidth;

    // AND-OR mux over every (share, idx) slot; exactly one slot matches.
    always_comb begin
        word = '0;
        for (int unsigned s = 32'd0; s < Shares; s++) begin
            for (int unsigned w = 32'd0; w < NumWords; w++) begin
                word = word | ({WordWidth{(share == ShareW'(s)) && (idx == IdxW'(w))}}
                               & key[s*KeyWidth + w*WordWidth +: WordWidth]);
            end
        end
    end

endmodule

// File: rtl/key_sideload_serializer.sv
// -----------------------------------------------------------------------------
// key_sideload_serializer
// Captures one sideload key (all shares) on a valid/ready handshake and
// streams it as WordWidth-bit slices, share 0 first, slice 0 first. The held
// key is wiped after the final beat or when clear_i is asserted.
//
// Optional build macro KEY_SERIALIZE_UNMASK_EN: when defined, the shares are
// XOR-folded at capture and only the NumWords slices of the plain key are
// streamed (word_share_o tied to 0).
//
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   key_valid_i/ready_o- key capture handshake (ready only in IDLE)
//   key_i              - sideload key, all shares
//   clear_i            - abort transfer and wipe held key (highest priority)
//   word_valid_o/ready_i - slice handshake
//   word_o             - current slice (zero whenever not valid)
//   word_share_o       - share index of the slice
//   word_idx_o         - slice index within its share
//   word_last_o        - final slice of the key
//   busy_o             - transfer or wipe in progress
// -----------------------------------------------------------------------------
module key_sideload_serializer
    import key_sideload_serializer_pkg::*;
#(
    parameter int unsigned Shares    = key_sideload_serializer_pkg::Shares,
    parameter int unsigned KeyWidth  = key_sideload_serializer_pkg::KeyWidth,
    parameter int unsigned WordWidth = key_sideload_serializer_pkg::WordWidth
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        key_valid_i,
    output logic                                        key_ready_o,
    input  logic [$bits(hw_key_req_t)-1:0]              key_i,
    input  logic                                        clear_i,
    output logic                                        word_valid_o,
    input  logic                                        word_ready_i,
    output logic [WordWidth-1:0]                        word_o,
    output logic [idx_width(Shares)-1:0]                word_share_o,
    output logic [idx_width(KeyWidth/WordWidth)-1:0]    word_idx_o,
    output logic                                        word_last_o,
    output logic                                        busy_o
);

    localparam int unsigned NumWords = KeyWidth / WordWidth;
    localparam int unsigned ShareW   = idx_width(Shares);
    localparam int unsigned IdxW     = idx_width(NumWords);
`ifdef KEY_SERIALIZE_UNMASK_EN
    localparam int unsigned HeldShares = 32'd1;
`else
    localparam int unsigned HeldShares = Shares;
`endif
    localparam logic [ShareW-1:0] LastShare = ShareW'(HeldShares - 32'd1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NumWords - 32'd1);

    if (KeyWidth % WordWidth != 32'd0) begin : g_word_width_check
        $error("KeyWidth must be a multiple of WordWidth");
    end
    if (Shares * KeyWidth != $bits(hw_key_req_t)) begin : g_key_type_check
        $error("Shares/KeyWidth do not match hw_key_req_t");
    end

    key_ser_state_e                     state_r, state_s;
    hw_key_req_t                        key_req_s;
    logic [HeldShares*KeyWidth-1:0]     key_r, key_cap_s;
    logic [ShareW-1:0]                  share_r;
    logic [IdxW-1:0]                    idx_r;
    logic                               ready_en_r;
    logic                               cap_s, beat_s, wipe_s, last_s, send_s;
    logic [WordWidth-1:0]               slice_s;

    assign key_req_s = hw_key_req_t'(key_i);

`ifdef KEY_SERIALIZE_UNMASK_EN
    // Fold all shares into the plain key at capture time.
    always_comb begin
        key_cap_s = '0;
        for (int unsigned s = 32'd0; s < Shares; s++) begin
            key_cap_s = key_cap_s ^ key_req_s.key[s];
        end
    end
`else
    assign key_cap_s = key_req_s.key;
`endif

    assign last_s = (share_r == LastShare) && (idx_r == LastIdx);

    // Next-state logic; clear_i overrides both capture and slice handshakes.
    always_comb begin
        state_s = state_r;
        cap_s   = 1'b0;
        beat_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_i) begin
                    state_s = WIPE;
                end else if (key_valid_i && ready_en_r) begin
                    cap_s   = 1'b1;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (clear_i) begin
                    state_s = WIPE;
                end else if (word_ready_i) begin
                    beat_s  = 1'b1;
                    state_s = last_s ? WIPE : SEND;
                end else begin
                    state_s = SEND;
                end
            end
            WIPE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = WIPE;
            end
        endcase
        wipe_s = (state_s == WIPE);
    end

    // State register; ready_en_r keeps key_ready_o low until the first clock after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ready_en_r <= 1'b1;
        end
    end

    // Held key: zeroed on the way into WIPE so no key bits outlive the transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_r <= '0;
        end else if (wipe_s) begin
            key_r <= '0;
        end else if (cap_s) begin
            key_r <= key_cap_s;
        end else begin
            key_r <= key_r;
        end
    end

    // Share/slice counters: slice index wraps into the next share.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            share_r <= '0;
            idx_r   <= '0;
        end else if (wipe_s || cap_s) begin
            share_r <= '0;
            idx_r   <= '0;
        end else if (beat_s) begin
            if (idx_r == LastIdx) begin
                idx_r   <= '0;
                share_r <= share_r + ShareW'(32'd1);
            end else begin
                idx_r   <= idx_r + IdxW'(32'd1);
                share_r <= share_r;
            end
        end else begin
            share_r <= share_r;
            idx_r   <= idx_r;
        end
    end

    key_slice_mux #(
        .Shares    (HeldShares),
        .KeyWidth  (KeyWidth),
        .WordWidth (WordWidth),
        .ShareW    (ShareW),
        .IdxW      (IdxW)
    ) u_key_slice_mux (
        .key   (key_r),
        .share (share_r),
        .idx   (idx_r),
        .word  (slice_s)
    );

    // All outputs decode registered state only; key data is gated outside SEND.
    assign send_s       = (state_r == SEND);
    assign key_ready_o  = ready_en_r && (state_r == IDLE);
    assign word_valid_o = send_s;
    assign word_o       = send_s ? slice_s : '0;
    assign word_idx_o   = send_s ? idx_r : '0;
    assign word_last_o  = send_s && last_s;
    assign busy_o       = (state_r != IDLE);
`ifdef KEY_SERIALIZE_UNMASK_EN
    assign word_share_o = '0;
`else
    assign word_share_o = send_s ? share_r : '0;
`endif

endmodule
